// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 serial transmitter with a one-byte holding register.
// A byte is accepted on tx_start while tx_ready is high. The shifter then
// drives start, data (LSB first), optional parity and stop bits, each bit
// lasting CLKS_PER_BIT clocks.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between data bit 7 and the stop bit (8-E-1, 11-bit frame).
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             hold_full;
  logic [7:0]       hold_data;
  logic [7:0]       shift_q;
  logic             load;
  logic             shift_en;
  logic             done_set;
  logic             line_d;
  logic             bit_end;
  logic             accept;
  logic             tx_done_p0;
  logic             tx_done_p1;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // Holding register handshake: a full register blocks new requests, and a
  // request that arrives while full is flagged and dropped.
  assign accept     = tx_start & ~hold_full;
  assign tx_ready   = ~hold_full;
  assign tx_overrun = rst & tx_start & hold_full;
  assign tx_busy    = (state_q != IDLE);
  assign bit_end    = (clk_cnt_q == BIT_LAST);
  assign tx_done    = tx_done_p1;

  // Next-state, bit timer and line level for the shifter FSM.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    done_set  = 1'b0;
    line_d    = 1'b1;
    case (state_q)
      IDLE: begin
        line_d    = 1'b1;
        clk_cnt_d = '0;
        if (hold_full) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = START_BIT;
        end
      end
      START_BIT: begin
        line_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA_BITS;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        line_d = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_en  = 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        line_d = parity_q;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = STOP_BIT;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP_BIT: begin
        line_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          done_set  = 1'b1;
          // A waiting byte starts immediately so frames run back-to-back.
          if (hold_full) begin
            load      = 1'b1;
            bit_cnt_d = '0;
            state_d   = START_BIT;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        line_d    = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Control state: FSM, counters, holding flag, registered line and done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      hold_full  <= 1'b0;
      tx_serial  <= 1'b1;
      tx_done_p0 <= 1'b0;
      tx_done_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      // ---- stage p0: line level registered one cycle behind the FSM ----
      tx_serial  <= line_d;
      tx_done_p0 <= done_set;
      // ---- stage p1: done aligned to the cycle after the last stop cycle ----
      tx_done_p1 <= tx_done_p0;
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Data path: holding byte, shift register and parity captured at load.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx_byte;
    end
    if (load) begin
      shift_q <= hold_data;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
`ifdef UART_TX_PARITY_EN
    if (load) begin
      parity_q <= ^hold_data;
    end
`endif
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4: reset values, start latency,
// table of single frames, back-to-back frames, overrun and mid-frame reset.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_overrun;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i is the i-th bit on the wire: start, d0..d7, stop
    logic       par;
  } vec_t;

  vec_t vecs[6];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_byte    (tx_byte),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_overrun (tx_overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid low-phase, away from both clock edges.
  always @(negedge clk) begin
    #3;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tx_ready got %b expected 1", tx_ready);
    end
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_low(input string name);
    int n = 0;
    while (tx_serial !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx_serial !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: start bit got %b expected 0 (timeout)", name, tx_serial);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge of the cycle following the last stop-bit cycle.
  task automatic run_frame(output logic [10:0] got, output logic stable, output logic done_end);
    got    = '0;
    stable = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) got[b] = tx_serial;
        else if (tx_serial !== got[b]) stable = 1'b0;
        if (!(b == 0 && c == 0) && tx_done === 1'b1) stable = 1'b0;
        @(negedge clk);
      end
    end
    done_end = tx_done;
  endtask

  function automatic logic [10:0] expected(input vec_t v);
    if (NB == 10) return {1'b0, v.frame};
    else          return {1'b1, v.par, v.frame[8:1], 1'b0};
  endfunction

  logic [10:0] got;
  logic        stable, done_end;
  int          d0, o0, n, lows;

  initial begin
    vecs[0] = '{data: 8'h55, frame: 10'b1_01010101_0, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0, par: 1'b0};
    vecs[3] = '{data: 8'h07, frame: 10'b1_00000111_0, par: 1'b1};
    vecs[4] = '{data: 8'h80, frame: 10'b1_10000000_0, par: 1'b1};
    vecs[5] = '{data: 8'h3C, frame: 10'b1_00111100_0, par: 1'b0};

    // Reset
    rst = 1'b0; tx_start = 1'b0; tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_serial",  tx_serial,  1'b1);
    check("rst_ready",   tx_ready,   1'b1);
    check("rst_busy",    tx_busy,    1'b0);
    check("rst_done",    tx_done,    1'b0);
    check("rst_overrun", tx_overrun, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Single byte 0x55 with start latency
    d0 = done_cnt;
    send(8'h55);
    check("acc_ready_low", tx_ready, 1'b0);
    check("acc_busy_low",  tx_busy,  1'b0);
    n = 0;
    while (tx_serial !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", n, 2);
    check("busy_in_frame", tx_busy, 1'b1);
    check("ready_in_frame", tx_ready, 1'b1);
    run_frame(got, stable, done_end);
    check("single_frame", got, expected(vecs[0]));
    check("single_stable", stable, 1'b1);
    check("single_done", done_end, 1'b1);
    @(negedge clk);
    check("single_done_once", done_cnt - d0, 1);
    check("single_busy_after", tx_busy, 1'b0);
    check("single_done_drop", tx_done, 1'b0);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      wait_low("tbl_start");
      run_frame(got, stable, done_end);
      check($sformatf("tbl_frame_%0h", vecs[i].data), got, expected(vecs[i]));
      check("tbl_stable", stable, 1'b1);
      check("tbl_done", done_end, 1'b1);
      @(negedge clk);
      check("tbl_busy_after", tx_busy, 1'b0);
    end

    // Back-to-back 0xA5 then 0x3C
    d0 = done_cnt;
    send(8'hA5);
    send(8'h3C);
    wait_low("b2b_start1");
    run_frame(got, stable, done_end);
    check("b2b_frame1", got, expected('{data: 8'hA5, frame: 10'b1_10100101_0, par: 1'b0}));
    check("b2b_done1", done_end, 1'b1);
    check("b2b_no_gap", tx_serial, 1'b0);
    run_frame(got, stable, done_end);
    check("b2b_frame2", got, expected(vecs[5]));
    check("b2b_stable2", stable, 1'b1);
    check("b2b_done2", done_end, 1'b1);
    @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 2);

    // Overrun: 0x33 arrives while 0x22 is held and is dropped
    d0 = done_cnt;
    o0 = ovr_cnt;
    send(8'h11);
    send(8'h22);
    wait_low("ovr_start1");
    fork
      run_frame(got, stable, done_end);
      begin
        repeat (5) @(negedge clk);
        tx_byte  = 8'h33;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check("ovr_frame1", got, expected('{data: 8'h11, frame: 10'b1_00010001_0, par: 1'b0}));
    check("ovr_done1", done_end, 1'b1);
    wait_low("ovr_start2");
    run_frame(got, stable, done_end);
    check("ovr_frame2", got, expected('{data: 8'h22, frame: 10'b1_00100010_0, par: 1'b0}));
    check("ovr_done2", done_end, 1'b1);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) lows++;
    end
    check("ovr_no_third_frame", lows, 0);
    check("ovr_pulse_count", ovr_cnt - o0, 1);
    check("ovr_done_count", done_cnt - d0, 2);

    // Reset during data bit 3 of 0xF0
    d0 = done_cnt;
    send(8'hF0);
    wait_low("rstmid_start");
    repeat (17) @(negedge clk);
    check("rstmid_pre_bit3", tx_serial, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_serial", tx_serial, 1'b1);
    check("rstmid_ready",  tx_ready,  1'b1);
    check("rstmid_busy",   tx_busy,   1'b0);
    rst = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) lows++;
    end
    check("rstmid_idle", lows, 0);
    check("rstmid_no_done", done_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
